// File: rtl/chip8_pkg.sv
// chip8_pkg: shared definitions for the CHIP-8 instruction fetch stage.
//   ADDR_W        byte address width (4 KiB address space)
//   RESET_PC      program counter after reset (CHIP-8 program start)
//   fetch_state_t fetch sequencer states
//   opcode_t      16-bit big-endian CHIP-8 opcode
package chip8_pkg;

  localparam int ADDR_W = 12;
  localparam logic [ADDR_W-1:0] RESET_PC = 12'h200;

  typedef enum logic [2:0] {
    REQ_HI  = 3'd0,
    WAIT_HI = 3'd1,
    REQ_LO  = 3'd2,
    WAIT_LO = 3'd3,
    VALID   = 3'd4
  } fetch_state_t;

  typedef logic [15:0] opcode_t;

endpackage

// File: rtl/fetch_prefetch_buf.sv
// fetch_prefetch_buf: one-entry holding buffer for an opcode fetched ahead
// of the decoder (used only when FETCH_PREFETCH_EN is defined).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push_i                write push_op_i/push_pc_i into the entry, mark full
//   pop_i                 entry consumed, mark empty
//   flush_i               discard the entry (wins over push/pop)
//   full_o                entry holds a valid opcode
//   op_o, pc_o            stored opcode and the address of its high byte
module fetch_prefetch_buf
  import chip8_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  opcode_t         push_op_i,
  input  logic [PC_W-1:0] push_pc_i,
  output logic            full_o,
  output opcode_t         op_o,
  output logic [PC_W-1:0] pc_o
);

  logic            full_q;
  opcode_t         op_q;
  logic [PC_W-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      op_q   <= '0;
      pc_q   <= '0;
    end else begin
      if (flush_i)     full_q <= 1'b0;
      else if (push_i) full_q <= 1'b1;
      else if (pop_i)  full_q <= 1'b0;
      if (push_i && !flush_i) begin
        op_q <= push_op_i;
        pc_q <= push_pc_i;
      end
    end
  end

  assign full_o = full_q;
  assign op_o   = op_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: CHIP-8 instruction fetch stage. Holds the PC, reads the high
// byte at PC and the low byte at PC+1 from the byte-wide memory read port,
// and presents the big-endian opcode to the decoder.
// Configuration macro: FETCH_PREFETCH_EN compiles in a one-entry prefetch
// buffer so the next opcode is fetched while the current one waits.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem_read, mem_read_addr     one-cycle read strobe and byte address
//   mem_read_data, mem_read_ack returned byte, ack one cycle after mem_read
//   op_valid, op, op_pc         fetched opcode and address of its high byte
//   op_ready                    decoder accepts op when op_valid=1
//   pc_load, pc_load_addr       redirect, highest priority
//   dbg_state                   current sequencer state (observation only)
// Handshake: an opcode transfers on a rising edge where op_valid and
// op_ready are both 1; op/op_pc stay stable while op_valid=1 and op_ready=0.
module fetch_unit #(
  parameter int                ADDR_W   = chip8_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = chip8_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_read,
  output logic [ADDR_W-1:0]      mem_read_addr,
  input  logic [7:0]             mem_read_data,
  input  logic                   mem_read_ack,
  output logic                   op_valid,
  output logic [15:0]            op,
  output logic [ADDR_W-1:0]      op_pc,
  input  logic                   op_ready,
  input  logic                   pc_load,
  input  logic [ADDR_W-1:0]      pc_load_addr,
  output chip8_pkg::fetch_state_t dbg_state
);

  import chip8_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] op_pc_q, op_pc_d;
  logic [7:0]        hi_q, hi_d;
  opcode_t           op_q, op_d;
  logic              op_valid_q, op_valid_d;
  logic              accept;

`ifdef FETCH_PREFETCH_EN
  logic              buf_push, buf_pop, buf_flush, buf_full;
  opcode_t           buf_op;
  logic [ADDR_W-1:0] buf_pc;

  fetch_prefetch_buf #(.PC_W(ADDR_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (buf_push),
    .pop_i     (buf_pop),
    .flush_i   (buf_flush),
    .push_op_i ({hi_q, mem_read_data}),
    .push_pc_i (pc_q),
    .full_o    (buf_full),
    .op_o      (buf_op),
    .pc_o      (buf_pc)
  );
`endif

  assign accept = op_valid_q & op_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= REQ_HI;
      pc_q       <= RESET_PC;
      op_pc_q    <= '0;
      hi_q       <= '0;
      op_q       <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_pc_q    <= op_pc_d;
      hi_q       <= hi_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_pc_d    = op_pc_q;
    hi_d       = hi_q;
    op_d       = op_q;
    op_valid_d = op_valid_q & ~accept;
`ifdef FETCH_PREFETCH_EN
    buf_push   = 1'b0;
    buf_pop    = 1'b0;
    buf_flush  = 1'b0;
`endif
    case (state_q)
      REQ_HI:  state_d = WAIT_HI;
      WAIT_HI: begin
        if (mem_read_ack) begin
          hi_d    = mem_read_data;
          state_d = REQ_LO;
        end
      end
      REQ_LO:  state_d = WAIT_LO;
      WAIT_LO: begin
        if (mem_read_ack) begin
          pc_d = pc_q + ADDR_W'(2);
`ifdef FETCH_PREFETCH_EN
          // Deliver straight to the output slot when it is free (or being
          // freed this cycle); otherwise park it and stall the sequencer.
          if (!op_valid_q || accept) begin
            op_d       = {hi_q, mem_read_data};
            op_pc_d    = pc_q;
            op_valid_d = 1'b1;
            state_d    = REQ_HI;
          end else begin
            buf_push = 1'b1;
            state_d  = VALID;
          end
`else
          op_d       = {hi_q, mem_read_data};
          op_pc_d    = pc_q;
          op_valid_d = 1'b1;
          state_d    = VALID;
`endif
        end
      end
      VALID: begin
`ifdef FETCH_PREFETCH_EN
        // Output slot and buffer both full: on accept the buffered opcode
        // moves up with no bubble and fetching resumes next cycle.
        if (accept) begin
          op_d       = buf_op;
          op_pc_d    = buf_pc;
          op_valid_d = buf_full;
          buf_pop    = 1'b1;
          state_d    = REQ_HI;
        end
`else
        if (accept) state_d = REQ_HI;
`endif
      end
      default: state_d = REQ_HI;
    endcase

    // Redirect overrides everything; an in-flight byte is dropped because
    // REQ_HI never looks at mem_read_ack.
    if (pc_load) begin
      pc_d       = pc_load_addr;
      state_d    = REQ_HI;
      op_valid_d = 1'b0;
`ifdef FETCH_PREFETCH_EN
      buf_flush  = 1'b1;
`endif
    end
  end

  // Reset state is REQ_HI, so the strobe is gated to stay low during reset.
  assign mem_read      = rst_n & ((state_q == REQ_HI) | (state_q == REQ_LO));
  assign mem_read_addr = !rst_n ? '0 :
                         (state_q == REQ_LO) ? pc_q + ADDR_W'(1) : pc_q;
  assign op_valid      = op_valid_q;
  assign op            = op_q;
  assign op_pc         = op_pc_q;
  assign dbg_state     = state_q;

endmodule
